// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkt_ctrl
//  Purpose  : Packet framer behind a UART byte receiver. It hunts for a
//             start-of-frame byte, then takes LEN, LEN payload bytes and an
//             XOR checksum. The payload is buffered and released through a
//             valid/ready byte stream. Framing, checksum, overrun and
//             inter-byte timeout errors are reported as one-cycle pulses.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_3125     in   system clock
//    rst_n        in   synchronous active-low reset
//    byte_in      in   [7:0]  received byte
//    byte_valid   in   one-cycle strobe qualifying byte_in
//    out_data     out  [7:0]  payload byte to consumer
//    out_valid    out  out_data valid
//    out_ready    in   consumer accepts out_data
//    out_last     out  high with the final payload byte
//    pkt_len      out  [LEN_W-1:0] length of the packet being delivered
//    busy         out  high whenever the parser is not idle
//    err_chk      out  pulse, checksum mismatch
//    err_len      out  pulse, length byte is 0 or above MAX_LEN
//    err_overrun  out  pulse, byte strobe arrived while delivering
//    err_timeout  out  pulse, inter-byte timeout
//    pkt_count    out  [7:0]  good packets delivered, wraps 255->0
// ----------------------------------------------------------------------------
//  Build option
//    UART_RX_PKT_TIMEOUT_EN : when defined, an inter-byte timeout counter is
//    built for LEN/PAYLOAD/CHECK. When undefined, err_timeout is tied low and
//    the parser waits indefinitely for the next byte.
// ============================================================================
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SOF         = 8'h7E,
  parameter int         MAX_LEN     = 8,
  parameter int         LEN_W       = 4,
  parameter int         TIMEOUT_CYC = 400,
  parameter int         TO_W        = 10
) (
  input  logic             clk_3125,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [LEN_W-1:0] pkt_len,
  output logic             busy,
  output logic             err_chk,
  output logic             err_len,
  output logic             err_overrun,
  output logic             err_timeout,
  output logic [7:0]       pkt_count
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_len     = 3'd1;
  localparam logic [2:0] c_payload = 3'd2;
  localparam logic [2:0] c_check   = 3'd3;
  localparam logic [2:0] c_deliver = 3'd4;

  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [7:0]       c_max_len = 8'(MAX_LEN);

  // Buffer is sized to the full index range so any LEN_W-bit index is legal.
  localparam int c_depth = 1 << LEN_W;

  logic [2:0]       state_q,     state_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic [7:0]       chk_q,       chk_d;
  logic [LEN_W-1:0] wr_idx_q,    wr_idx_d;
  logic [LEN_W-1:0] rd_idx_q,    rd_idx_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic [LEN_W-1:0] pkt_len_q,   pkt_len_d;
  logic             busy_q,      busy_d;
  logic             err_chk_q,   err_chk_d;
  logic             err_len_q,   err_len_d;
  logic             err_ovr_q,   err_ovr_d;
  logic [7:0]       pkt_count_q, pkt_count_d;

  logic [7:0]       pld_q [0:c_depth-1];
  logic             pld_we;
  logic [LEN_W-1:0] rd_next;
  logic             to_expire;

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_to_q, err_to_d;
  logic            timed_state;

  assign timed_state = (state_q == c_len) || (state_q == c_payload) ||
                       (state_q == c_check);
  // A strobe in the expiry cycle wins, so expiry requires no strobe.
  assign to_expire   = timed_state && !byte_valid && (to_cnt_q == c_to_last);
`else
  assign to_expire   = 1'b0;
`endif

  assign rd_next = rd_idx_q + c_len_one;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    chk_d       = chk_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pkt_len_d   = pkt_len_q;
    pkt_count_d = pkt_count_q;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_ovr_d   = 1'b0;
    pld_we      = 1'b0;

    case (state_q)
      c_idle: begin
        if (byte_valid && (byte_in == SOF)) begin
          state_d = c_len;
        end
      end

      c_len: begin
        if (byte_valid) begin
          // SOF (0x7E) is above any legal MAX_LEN, so it lands here too.
          if ((byte_in == 8'd0) || (byte_in > c_max_len)) begin
            err_len_d = 1'b1;
            state_d   = c_idle;
          end else begin
            len_d    = byte_in[LEN_W-1:0];
            chk_d    = byte_in;
            wr_idx_d = '0;
            state_d  = c_payload;
          end
        end
      end

      c_payload: begin
        if (byte_valid) begin
          pld_we   = 1'b1;
          chk_d    = chk_q ^ byte_in;
          wr_idx_d = wr_idx_q + c_len_one;
          if (wr_idx_q == (len_q - c_len_one)) begin
            state_d = c_check;
          end
        end
      end

      c_check: begin
        if (byte_valid) begin
          if (byte_in == chk_q) begin
            // Preload the first byte so out_valid rises the next cycle.
            state_d     = c_deliver;
            pkt_len_d   = len_q;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
            out_data_d  = pld_q[0];
            out_last_d  = (len_q == c_len_one);
          end else begin
            err_chk_d = 1'b1;
            state_d   = c_idle;
          end
        end
      end

      c_deliver: begin
        // Incoming bytes cannot be stored while delivering; flag and drop.
        if (byte_valid) begin
          err_ovr_d = 1'b1;
        end
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'd0;
            pkt_count_d = pkt_count_q + 8'd1;
            state_d     = c_idle;
          end else begin
            rd_idx_d   = rd_next;
            out_data_d = pld_q[rd_next];
            out_last_d = (rd_next == (len_q - c_len_one));
          end
        end
      end

      default: begin
        state_d = c_idle;
      end
    endcase

    // Expiry only happens without a strobe, so nothing else changed above.
    if (to_expire) begin
      state_d = c_idle;
    end
  end

  assign busy_d = (state_d != c_idle);

`ifdef UART_RX_PKT_TIMEOUT_EN
  always_comb begin
    to_cnt_d = to_cnt_q;
    err_to_d = to_expire;
    if (timed_state) begin
      // Clear on every strobe and on entry into the next timed state.
      if (byte_valid || (state_d != state_q)) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else if (state_d != state_q) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state_q     <= c_idle;
      len_q       <= '0;
      chk_q       <= 8'd0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_len_q   <= '0;
      busy_q      <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
      pkt_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_len_q   <= pkt_len_d;
      busy_q      <= busy_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_ovr_q   <= err_ovr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Payload storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk_3125) begin
    if (pld_we) begin
      pld_q[wr_idx_q] <= byte_in;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign pkt_len     = pkt_len_q;
  assign busy        = busy_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_overrun = err_ovr_q;
  assign pkt_count   = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_pkt_ctrl
//  Purpose  : Directed self-checking bench for uart_rx_pkt_ctrl. Inputs are
//             driven right after a rising edge and outputs are sampled 1ns
//             after the rising edge that registered them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pkt_ctrl;

  logic       clk_3125;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] pkt_len;
  logic       busy;
  logic       err_chk;
  logic       err_len;
  logic       err_overrun;
  logic       err_timeout;
  logic [7:0] pkt_count;

  int checks = 0;
  int errors = 0;

  uart_rx_pkt_ctrl dut (
    .clk_3125    (clk_3125),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .pkt_len     (pkt_len),
    .busy        (busy),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .pkt_count   (pkt_count)
  );

  initial clk_3125 = 1'b0;
  always #5 clk_3125 = ~clk_3125;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_3125);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  // No-error check bundled as one compare of the four pulse outputs.
  task automatic check_no_err(input string tag);
    check(tag, {err_chk, err_len, err_overrun, err_timeout}, 4'b0000);
  endtask

  logic [7:0] exp_b;
  int         seen_to;

  initial begin
    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("rst_outputs", {out_data, out_valid, out_last, pkt_len, busy, pkt_count}, 32'h0);
    check_no_err("rst_err");
    rst_n = 1'b1;
    tick();

    // ---- Good packet 7E 03 11 22 33 03 ----
    strobe(8'h7E);
    check("busy_after_sof", busy, 1'b1);
    strobe(8'h03);
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    check("no_valid_before_chk", out_valid, 1'b0);
    strobe(8'h03);
    check("good_b0", {out_valid, out_last, out_data}, {2'b10, 8'h11});
    check("good_len", pkt_len, 4'd3);
    check_no_err("good_err0");
    tick();
    check("good_b1", {out_valid, out_last, out_data}, {2'b10, 8'h22});
    tick();
    check("good_b2", {out_valid, out_last, out_data}, {2'b11, 8'h33});
    check("good_cnt_before", pkt_count, 8'd0);
    tick();
    check("good_done", {out_valid, busy}, 2'b00);
    check("good_cnt", pkt_count, 8'd1);
    check_no_err("good_err_end");

    // ---- Bad checksum 7E 02 AA 55 00 (correct FD) ----
    strobe(8'h7E);
    strobe(8'h02);
    strobe(8'hAA);
    strobe(8'h55);
    strobe(8'h00);
    check("badchk_pulse", err_chk, 1'b1);
    check("badchk_novalid", {out_valid, busy}, 2'b00);
    tick();
    check("badchk_pulse_end", err_chk, 1'b0);

    // ---- Junk then good 1-byte packet: 00 FF 7E 01 5A 5B ----
    strobe(8'h00);
    strobe(8'hFF);
    check("junk_idle", busy, 1'b0);
    strobe(8'h7E);
    strobe(8'h01);
    strobe(8'h5A);
    strobe(8'h5B);
    check("one_b0", {out_valid, out_last, out_data}, {2'b11, 8'h5A});
    check("one_len", pkt_len, 4'd1);
    tick();
    check("one_done", {out_valid, pkt_count}, {1'b0, 8'd2});

    // ---- Length errors ----
    strobe(8'h7E);
    strobe(8'h00);
    check("len0_err", {err_len, busy}, 2'b10);
    tick();
    check("len0_err_end", err_len, 1'b0);
    strobe(8'h7E);
    strobe(8'h09);
    check("len9_err", {err_len, busy}, 2'b10);

    // ---- Max length: 7E 08 01..08 00 (08 ^ 01^..^08 = 00) ----
    strobe(8'h7E);
    strobe(8'h08);
    check("len8_ok", err_len, 1'b0);
    for (int i = 1; i <= 8; i++) strobe(8'(i));
    strobe(8'h00);
    check("len8_pktlen", pkt_len, 4'd8);
    for (int i = 1; i <= 8; i++) begin
      exp_b = 8'(i);
      check($sformatf("len8_b%0d", i), {out_valid, out_last, out_data},
            {1'b1, (i == 8), exp_b});
      tick();
    end
    check("len8_done", {out_valid, busy, pkt_count}, {2'b00, 8'd3});

    // ---- Backpressure and overrun ----
    strobe(8'h7E);
    strobe(8'h03);
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    out_ready = 1'b0;
    strobe(8'h03);
    check("bp_hold0", {out_valid, out_last, out_data}, {2'b10, 8'h11});
    tick();
    tick();
    check("bp_hold2", {out_valid, out_last, out_data}, {2'b10, 8'h11});
    strobe(8'h7E);
    check("ovr_pulse", err_overrun, 1'b1);
    check("ovr_hold", {out_valid, out_data, busy}, {1'b1, 8'h11, 1'b1});
    tick();
    check("ovr_pulse_end", err_overrun, 1'b0);
    check("bp_hold4", {out_valid, out_last, out_data}, {2'b10, 8'h11});
    out_ready = 1'b1;
    tick();
    check("bp_b1", {out_valid, out_last, out_data}, {2'b10, 8'h22});
    tick();
    check("bp_b2", {out_valid, out_last, out_data}, {2'b11, 8'h33});
    tick();
    check("bp_done", {out_valid, busy, pkt_count}, {2'b00, 8'd4});

`ifdef UART_RX_PKT_TIMEOUT_EN
    // ---- Timeout: AA strobe is cycle 0, expiry registered by edge 400 ----
    strobe(8'h7E);
    strobe(8'h02);
    strobe(8'hAA);
    for (int i = 1; i < 400; i++) tick();
    check("to_not_yet", {err_timeout, busy}, 2'b01);
    tick();
    check("to_pulse", {err_timeout, busy}, 2'b10);
    tick();
    check("to_pulse_end", err_timeout, 1'b0);

    // Strobe landing exactly on the expiry cycle wins.
    strobe(8'h7E);
    strobe(8'h02);
    strobe(8'hAA);
    for (int i = 1; i < 400; i++) tick();
    strobe(8'hBB);
    check("to_race", {err_timeout, busy}, 2'b01);
    for (int i = 1; i < 400; i++) tick();
    strobe(8'h13);
    check("to_race_err", {err_timeout, err_chk}, 2'b00);
`else
    // ---- No timeout logic: the parser waits indefinitely ----
    strobe(8'h7E);
    strobe(8'h02);
    strobe(8'hAA);
    seen_to = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (err_timeout !== 1'b0) seen_to++;
    end
    check("noto_pulses", seen_to, 0);
    check("noto_busy", busy, 1'b1);
    strobe(8'hBB);
    strobe(8'h13);
`endif
    check("late_b0", {out_valid, out_last, out_data}, {2'b10, 8'hAA});
    tick();
    check("late_b1", {out_valid, out_last, out_data}, {2'b11, 8'hBB});
    tick();
    check("late_done", {out_valid, pkt_count}, {1'b0, 8'd5});

    // ---- Reset during PAYLOAD ----
    strobe(8'h7E);
    strobe(8'h03);
    strobe(8'h11);
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", {out_data, out_valid, out_last, pkt_len, busy, pkt_count}, 32'h0);
    check_no_err("midrst_err");
    rst_n = 1'b1;
    strobe(8'h22);
    strobe(8'h33);
    strobe(8'h03);
    check("midrst_discard", {out_valid, busy}, 2'b00);
    tick();
    check("midrst_discard2", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
